// File: rtl/decode_cycle_pkg.sv
// Shared decode constants for the RV32I ID stage: opcodes, ALU operation codes,
// immediate-format selectors and the main-decoder control bundle.
package decode_cycle_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef struct packed {
    logic       reg_write;
    imm_src_e   imm_src;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// x0 hard-wired to zero, and write-to-read bypass for same-cycle writeback.
module register_file
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic        WE3,
  input  logic [4:0]  A3,
  input  logic [31:0] WD3,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = WE3 && (A3 != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[A3] <= WD3;
    end
  end

  // Bypass lets the instruction in decode see the value being written back this cycle.
  always_comb begin
    RD1 = regs_q[A1];
    RD2 = regs_q[A2];
    if (A1 == 5'd0)              RD1 = '0;
    else if (wr_en && A3 == A1)  RD1 = WD3;
    if (A2 == 5'd0)              RD2 = '0;
    else if (wr_en && A3 == A2)  RD2 = WD3;
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I instruction-decode stage: control decode, immediate generation, register
// read, and the ID/EX pipeline register feeding execute.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RD_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  ctrl_t       ctrl_d;
  logic [2:0]  alu_ctrl_d;
  logic [31:0] imm_d;
  logic [31:0] rd1_d, rd2_d;

  logic        reg_write_q, alu_src_q, mem_write_q, result_src_q, branch_q;
  logic [2:0]  alu_ctrl_q;
  logic [31:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];

  function automatic logic [31:0] sign_extend(input logic [31:0] instr, input imm_src_e src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

  always_comb begin
    ctrl_d = '{reg_write: 1'b0, imm_src: IMM_I, alu_src: 1'b0, mem_write: 1'b0,
               result_src: 1'b0, branch: 1'b0, alu_op: 2'b00};
    case (opcode)
      OP_LOAD:   begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.result_src = 1'b1; end
      OP_STORE:  begin ctrl_d.imm_src = IMM_S; ctrl_d.alu_src = 1'b1; ctrl_d.mem_write = 1'b1; end
      OP_RTYPE:  begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = 2'b10; end
      OP_ITYPE:  begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.alu_op = 2'b10; end
      OP_BRANCH: begin ctrl_d.imm_src = IMM_B; ctrl_d.branch = 1'b1; ctrl_d.alu_op = 2'b01; end
      default: ;
    endcase
  end

  // funct7[5] only selects sub for register-register ops; addi ignores it.
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    case (ctrl_d.alu_op)
      2'b01: alu_ctrl_d = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl_d = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_d = ALU_SLT;
          3'b110:  alu_ctrl_d = ALU_OR;
          3'b111:  alu_ctrl_d = ALU_AND;
          default: alu_ctrl_d = ALU_ADD;
        endcase
      end
      default: alu_ctrl_d = ALU_ADD;
    endcase
  end

  assign imm_d = sign_extend(InstrD, ctrl_d.imm_src);

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .A1  (InstrD[19:15]),
    .A2  (InstrD[24:20]),
    .WE3 (RegWriteW),
    .A3  (RDW),
    .WD3 (ResultW),
    .RD1 (rd1_d),
    .RD2 (rd2_d)
  );

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      branch_q     <= 1'b0;
      alu_ctrl_q   <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
      pc4_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
    end else begin
      reg_write_q  <= ctrl_d.reg_write;
      alu_src_q    <= ctrl_d.alu_src;
      mem_write_q  <= ctrl_d.mem_write;
      result_src_q <= ctrl_d.result_src;
      branch_q     <= ctrl_d.branch;
      alu_ctrl_q   <= alu_ctrl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      rd_q         <= InstrD[11:7];
      pc_q         <= PCD;
      pc4_q        <= PCPlus4D;
      rs1_q        <= InstrD[19:15];
      rs2_q        <= InstrD[24:20];
    end
  end

  assign RegWriteE   = reg_write_q;
  assign ALUSrcE     = alu_src_q;
  assign MemWriteE   = mem_write_q;
  assign ResultSrcE  = result_src_q;
  assign BranchE     = branch_q;
  assign ALUControlE = alu_ctrl_q;
  assign RD1_E       = rd1_q;
  assign RD2_E       = rd2_q;
  assign Imm_Ext_E   = imm_q;
  assign RD_E        = rd_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign RS1_E       = rs1_q;
  assign RS2_E       = rs2_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed RV32I encodings plus randomized
// instructions and writebacks checked against a behavioural decode model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  typedef struct packed {
    logic        regw, alusrc, memw, ressrc, branch;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd;
    logic [31:0] pc, pc4;
    logic [4:0]  rs1, rs2;
  } dec_t;

  dec_t        act, exp_q;
  logic [31:0] mreg [32];
  int          n_cmp = 0;
  int          n_fail = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E)
  );

  always #5 clk = ~clk;

  assign act = {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, RS1_E, RS2_E};

  // Behavioural reference: decode tables plus arithmetic immediate extraction.
  function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] pc4, input logic we,
                                 input logic [4:0] rdw, input logic [31:0] wd);
    dec_t e;
    logic signed [31:0] s;
    int   f3;
    s = ins;
    f3 = int'(ins[14:12]);
    e = '0;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.pc = pc; e.pc4 = pc4;
    e.imm = 32'(s >>> 20);
    case (ins[6:0])
      7'h03: begin e.regw = 1; e.alusrc = 1; e.ressrc = 1; end
      7'h23: begin e.alusrc = 1; e.memw = 1;
                   e.imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]); end
      7'h63: begin e.branch = 1; e.aluc = 3'd1;
                   e.imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11)
                         | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
      7'h33, 7'h13: begin
        e.regw = 1; e.alusrc = (ins[6:0] == 7'h13);
        if (f3 == 0)      e.aluc = (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
        else if (f3 == 2) e.aluc = 3'd5;
        else if (f3 == 6) e.aluc = 3'd3;
        else if (f3 == 7) e.aluc = 3'd2;
      end
      default: ;
    endcase
    e.rd1 = (we && rdw != 0 && rdw == e.rs1) ? wd : mreg[e.rs1];
    e.rd2 = (we && rdw != 0 && rdw == e.rs2) ? wd : mreg[e.rs2];
    return e;
  endfunction

  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                       input logic we, input logic [4:0] rdw, input logic [31:0] wd);
    InstrD = ins; PCD = pc; PCPlus4D = pc4; RegWriteW = we; RDW = rdw; ResultW = wd;
    if (!rst) begin
      exp_q = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else begin
      exp_q = model(ins, pc, pc4, we, rdw, wd);
      if (we && rdw != 0) mreg[rdw] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycle(32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_567C, 1'b1, 5'd7, 32'hDEAD);
    cycle(32'h0080_A283, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 5'd7, 32'hDEAD);
    n_cmp++;
    if (act !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", act); end
    rst = 1'b1;
    cycle(32'h0000_0000, 32'h0, 32'h4, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (PCE !== 32'h0 || PCPlus4E !== 32'h4) begin
      n_fail++; $display("FAIL release_pc got=%h/%h want=0/4", PCE, PCPlus4E); end
    n_cmp++;
    if ({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE} !== 8'h0) begin
      n_fail++; $display("FAIL release_ctrl got=%b want=0", {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}); end
    // add x3,x7,x0: the write to x7 during reset must not have happened
    cycle(32'h0003_81B3, 32'h8, 32'hC, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (RD1_E !== 32'h0) begin n_fail++; $display("FAIL reset_wins got=%h want=0", RD1_E); end
  endtask

  task automatic test_lw();
    cycle(32'h0080_A283, 32'h100, 32'h104, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if ({RegWriteE, ALUSrcE, ResultSrcE, MemWriteE, BranchE} !== 5'b11100 || ALUControlE !== 3'b000) begin
      n_fail++; $display("FAIL lw_ctrl got=%b alu=%b want=11100 alu=000",
        {RegWriteE, ALUSrcE, ResultSrcE, MemWriteE, BranchE}, ALUControlE); end
    n_cmp++;
    if (Imm_Ext_E !== 32'h8 || RD_E !== 5'd5 || RS1_E !== 5'd1) begin
      n_fail++; $display("FAIL lw_fields got imm=%h rd=%0d rs1=%0d want imm=8 rd=5 rs1=1", Imm_Ext_E, RD_E, RS1_E); end
  endtask

  task automatic test_sw();
    cycle(32'hFE61_2E23, 32'h104, 32'h108, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (MemWriteE !== 1'b1 || RegWriteE !== 1'b0 || ALUSrcE !== 1'b1) begin
      n_fail++; $display("FAIL sw_ctrl got mw=%b rw=%b as=%b want 1 0 1", MemWriteE, RegWriteE, ALUSrcE); end
    n_cmp++;
    if (Imm_Ext_E !== 32'hFFFF_FFFC || RS1_E !== 5'd2 || RS2_E !== 5'd6) begin
      n_fail++; $display("FAIL sw_fields got imm=%h rs1=%0d rs2=%0d want FFFFFFFC 2 6", Imm_Ext_E, RS1_E, RS2_E); end
  endtask

  task automatic test_rtype();
    cycle(32'h0020_81B3, 32'h108, 32'h10C, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (ALUControlE !== 3'b000 || RegWriteE !== 1'b1 || ALUSrcE !== 1'b0) begin
      n_fail++; $display("FAIL add_ctrl got alu=%b rw=%b as=%b want 000 1 0", ALUControlE, RegWriteE, ALUSrcE); end
    cycle(32'h4020_81B3, 32'h10C, 32'h110, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (ALUControlE !== 3'b001) begin n_fail++; $display("FAIL sub_alu got=%b want=001", ALUControlE); end
    // addi with imm bit 10 set must still add
    cycle(32'h4000_8093, 32'h110, 32'h114, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (ALUControlE !== 3'b000 || ALUSrcE !== 1'b1) begin
      n_fail++; $display("FAIL addi_alu got alu=%b as=%b want 000 1", ALUControlE, ALUSrcE); end
  endtask

  task automatic test_beq();
    cycle(32'hFE20_8CE3, 32'h114, 32'h118, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || RegWriteE !== 1'b0) begin
      n_fail++; $display("FAIL beq_ctrl got br=%b alu=%b rw=%b want 1 001 0", BranchE, ALUControlE, RegWriteE); end
    n_cmp++;
    if (Imm_Ext_E !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL beq_imm got=%h want=FFFFFFF8", Imm_Ext_E); end
  endtask

  task automatic test_writeback_bypass();
    cycle(32'h0000_0013, 32'h200, 32'h204, 1'b1, 5'd1, 32'h0000_1234);
    cycle(32'h0020_81B3, 32'h204, 32'h208, 1'b1, 5'd2, 32'h0000_CAFE);
    n_cmp++;
    if (RD1_E !== 32'h0000_1234) begin n_fail++; $display("FAIL wb_rd1 got=%h want=00001234", RD1_E); end
    n_cmp++;
    if (RD2_E !== 32'h0000_CAFE) begin n_fail++; $display("FAIL bypass_rd2 got=%h want=0000CAFE", RD2_E); end
    cycle(32'h0020_81B3, 32'h208, 32'h20C, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (RD2_E !== 32'h0000_CAFE) begin n_fail++; $display("FAIL stored_rd2 got=%h want=0000CAFE", RD2_E); end
  endtask

  task automatic test_x0();
    cycle(32'h0000_01B3, 32'h20C, 32'h210, 1'b1, 5'd0, 32'h0000_FFFF);
    n_cmp++;
    if (RD1_E !== 32'h0 || RD2_E !== 32'h0) begin
      n_fail++; $display("FAIL x0_bypass got=%h/%h want=0/0", RD1_E, RD2_E); end
    cycle(32'h0000_01B3, 32'h210, 32'h214, 1'b0, 5'd0, 32'h0);
    n_cmp++;
    if (RD1_E !== 32'h0 || RD2_E !== 32'h0) begin
      n_fail++; $display("FAIL x0_read got=%h/%h want=0/0", RD1_E, RD2_E); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [6];
    logic [31:0] ins, pc;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h00};
    pc = 32'h1000;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 5)];
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      cycle(ins, pc, pc + 32'd4, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      n_cmp++;
      if (act !== exp_q) begin
        n_fail++; $display("FAIL random_%0d instr=%h got=%h want=%h", n, ins, act, exp_q); end
      pc = pc + 32'd4;
    end
  endtask

  initial begin
    rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_writeback_bypass();
    test_x0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Instruction-decode stage of the 5-stage RV32I pipeline; sits between fetch (IF/ID register) and execute.
- Decodes InstrD into control signals and a sign-extended immediate.
- Reads the register file; the writeback stage writes it.
- Registers everything into the ID/EX pipeline register feeding the execute stage.

Parameters:
- None. Fixed: XLEN = 32, 32 architectural registers, 5-bit register index.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-low reset
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback register-write enable
RDW  in  5  writeback destination register
ResultW  in  32  writeback data
RegWriteE  out  1  registered register-write enable
ALUSrcE  out  1  registered ALU operand-B select (1 = immediate)
MemWriteE  out  1  registered store enable
ResultSrcE  out  1  registered result select (1 = memory load data)
BranchE  out  1  registered branch flag
ALUControlE  out  3  registered ALU operation
RD1_E  out  32  registered rs1 value
RD2_E  out  32  registered rs2 value
Imm_Ext_E  out  32  registered sign-extended immediate
RD_E  out  5  registered rd field (InstrD[11:7])
PCE  out  32  registered PCD
PCPlus4E  out  32  registered PCPlus4D
RS1_E  out  5  registered InstrD[19:15]
RS2_E  out  5  registered InstrD[24:20]

Behaviour:
- Reset: on a rising edge with rst=0, every output above is cleared to 0 and all 32 registers are cleared to 0.
- Latency: one cycle. Outputs reflect the InstrD/PCD/PCPlus4D present at the preceding rising edge (rst=1). No stall or flush inputs; capture happens every cycle.
- Main decoder (opcode InstrD[6:0]); fields listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp:
  - lw 0000011: 1, I, 1, 0, 1, 0, 00
  - sw 0100011: 0, S, 1, 1, 0, 0, 00
  - R-type 0110011: 1, x, 0, 0, 0, 0, 10
  - I-ALU 0010011: 1, I, 1, 0, 0, 0, 10
  - beq 1100011: 0, B, 0, 0, 0, 1, 01
  - Any other opcode: all controls 0, ALUOp 00, ImmSrc I.
- ALU decoder:
  - ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
  - ALUOp 10, decoded on funct3 = InstrD[14:12]:
    - 000 -> 001 (sub) if opcode[5] and InstrD[30] are both 1, else 000 (add).
    - 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and).
    - Other funct3 -> 000.
- Immediates, all sign-extended from InstrD[31]:
  - I = InstrD[31:20].
  - S = {InstrD[31:25], InstrD[11:7]}.
  - B = {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 0}.
- Register file:
  - 2 combinational read ports, addressed by InstrD[19:15] and InstrD[24:20].
  - Write on rising edge when rst=1, RegWriteW=1 and RDW≠0. Writes to x0 are ignored; x0 always reads 0.
  - Internal bypass: if RegWriteW=1, RDW≠0 and RDW equals a read address, that port returns ResultW in the same cycle. A same-cycle writeback is therefore captured into RD1_E/RD2_E.
- Simultaneous reset and write: reset wins; no write occurs.
- Arithmetic is width-exact; no overflow handling here.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH.
  - ALUControl encodings: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
  - ImmSrc encodings: I=00, S=01, B=10.
- Sub-module register_file (32x32, synchronous reset, bypass).
- Control decoding, sign extension and the ID/EX register stay in decode_cycle.

Test Plan:
- Reset: hold rst=0 two cycles with arbitrary inputs -> all outputs 0. Release rst with InstrD=0x00000000, PCD=0, PCPlus4D=4 -> next edge PCE=0, PCPlus4E=4, all controls 0.
- lw x5,8(x1): InstrD=0x0080A283 -> RegWriteE=1, ALUSrcE=1, ResultSrcE=1, MemWriteE=0, BranchE=0, ALUControlE=000, Imm_Ext_E=0x00000008, RD_E=5, RS1_E=1.
- sw x6,-4(x2): InstrD=0xFE612E23 -> MemWriteE=1, RegWriteE=0, ALUSrcE=1, Imm_Ext_E=0xFFFFFFFC, RS1_E=2, RS2_E=6.
- R-type: add x3,x1,x2 (0x002081B3) -> ALUControlE=000, RegWriteE=1, ALUSrcE=0. sub (0x402081B3) -> ALUControlE=001.
- beq x1,x2,-8: InstrD=0xFE208CE3 -> BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFF8, RegWriteE=0.
- Writeback and bypass:
  - RegWriteW=1, RDW=1, ResultW=0x00001234 one cycle, then add x3,x1,x2 -> RD1_E=0x00001234.
  - Same-cycle write of x2=0xCAFE with that add -> RD2_E=0xCAFE.
  - RDW=0 write of 0xFFFF -> later x0 reads 0.
